// File: rtl/frame_write_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// frame_write_pkg : shared types and constants for frame_write_scheduler
// Revision: 1.0
// ============================================================================
package frame_write_pkg;

  localparam int FB_ADDR_W = 19;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    CLEAR = 2'd1,
    DRAW  = 2'd2
  } state_e;

  localparam logic [1:0] ST_ARB   = ARB;
  localparam logic [1:0] ST_CLEAR = CLEAR;
  localparam logic [1:0] ST_DRAW  = DRAW;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [6:0] w;
    logic [6:0] h;
    logic [7:0] color;
  } rect_t;

endpackage
`default_nettype wire

// File: rtl/frame_write_scheduler_if.sv
`default_nettype none
// ============================================================================
// frame_write_scheduler_if : requester handshake and Frame_Buffer write bus
// Revision: 1.0
// ============================================================================
interface frame_write_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic                 frame_start;
  logic                 clear_en;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*10-1:0] req_x;
  logic [NUM_REQ*10-1:0] req_y;
  logic [NUM_REQ*7-1:0] req_w;
  logic [NUM_REQ*7-1:0] req_h;
  logic [NUM_REQ*8-1:0] req_color;
  logic [18:0]          fb_wraddress;
  logic [7:0]           fb_data;
  logic                 fb_wren;
  logic [NUM_REQ-1:0]   rect_done;
  logic                 clear_done;
  logic                 busy;

  modport master (
    output frame_start, clear_en, req_valid, req_x, req_y, req_w, req_h, req_color,
    input  req_ready, fb_wraddress, fb_data, fb_wren, rect_done, clear_done, busy
  );

  modport slave (
    input  frame_start, clear_en, req_valid, req_x, req_y, req_w, req_h, req_color,
    output req_ready, fb_wraddress, fb_data, fb_wren, rect_done, clear_done, busy
  );
endinterface
`default_nettype wire

// File: rtl/frame_write_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : combinational round-robin grant, first request at or above ptr
// Revision: 1.0
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] grant_o
);

  logic found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (en_i && !found && req_i[i] && (((int'(ptr_i) + k) % NUM_REQ) == i)) begin
          grant_o[i] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/frame_write_scheduler.sv
`default_nettype none
// ============================================================================
// frame_write_scheduler : sole Frame_Buffer writer; frame clear + rect fills
// Revision: 1.0
// ============================================================================
module frame_write_scheduler
  import frame_write_pkg::*;
#(
  parameter int         NUM_REQ     = 4,
  parameter int         H_RES       = 640,
  parameter int         V_RES       = 480,
  parameter logic [7:0] CLEAR_COLOR = 8'h00
) (
  input  logic                  Clk,
  input  logic                  reset_n,
  frame_write_scheduler_if.slave bus
);

  localparam int                   PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(H_RES * V_RES - 1);
  localparam logic [FB_ADDR_W-1:0] H_STEP    = FB_ADDR_W'(H_RES);
  localparam logic [FB_ADDR_W-1:0] V_LIM     = FB_ADDR_W'(V_RES);

  logic [1:0]           state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  rect_t                rect_q, rect_d;
  logic [6:0]           col_q, col_d;
  logic [6:0]           row_q, row_d;
  logic [FB_ADDR_W-1:0] row_base_q, row_base_d;
  logic [FB_ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [FB_ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [7:0]           fb_data_q, fb_data_d;
  logic                 fb_wren_q, fb_wren_d;
  logic [NUM_REQ-1:0]   rect_done_q, rect_done_d;
  logic                 clear_done_q, clear_done_d;
  logic                 busy_q;

  logic                 clear_req;
  logic                 arb_en;
  logic [NUM_REQ-1:0]   grant;
  logic [FB_ADDR_W-1:0] x_cur, y_cur;
  logic                 clip, empty, last;

  // Ready is also held low during reset so every output reads 0 while reset_n=0.
  assign clear_req = bus.frame_start & bus.clear_en;
  assign arb_en    = reset_n & ~clear_req & (state_q == ST_ARB);

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .req_i   (bus.req_valid),
    .ptr_i   (ptr_q),
    .en_i    (arb_en),
    .grant_o (grant)
  );

  assign x_cur = FB_ADDR_W'(rect_q.x) + FB_ADDR_W'(col_q);
  assign y_cur = FB_ADDR_W'(rect_q.y) + FB_ADDR_W'(row_q);
  assign clip  = (x_cur >= H_STEP) || (y_cur >= V_LIM);
  assign empty = (rect_q.w == 7'd0) || (rect_q.h == 7'd0);
  assign last  = empty || ((col_q == rect_q.w - 7'd1) && (row_q == rect_q.h - 7'd1));

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    rect_d       = rect_q;
    col_d        = col_q;
    row_d        = row_q;
    row_base_d   = row_base_q;
    clr_addr_d   = clr_addr_q;
    fb_addr_d    = fb_addr_q;
    fb_data_d    = fb_data_q;
    fb_wren_d    = 1'b0;
    rect_done_d  = '0;
    clear_done_d = 1'b0;

    if (clear_req) begin
      state_d    = ST_CLEAR;
      clr_addr_d = '0;
    end else begin
      case (state_q)
        ST_ARB: begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
              rect_d.x     = bus.req_x[10*i +: 10];
              rect_d.y     = bus.req_y[10*i +: 10];
              rect_d.w     = bus.req_w[7*i +: 7];
              rect_d.h     = bus.req_h[7*i +: 7];
              rect_d.color = bus.req_color[8*i +: 8];
              owner_d      = PTR_W'(i);
              ptr_d        = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
              col_d        = '0;
              row_d        = '0;
              row_base_d   = FB_ADDR_W'(bus.req_y[10*i +: 10]) * H_STEP;
              state_d      = ST_DRAW;
            end
          end
        end
        ST_CLEAR: begin
          fb_wren_d = 1'b1;
          fb_addr_d = clr_addr_q;
          fb_data_d = CLEAR_COLOR;
          if (clr_addr_q == LAST_ADDR) begin
            clear_done_d = 1'b1;
            state_d      = ST_ARB;
          end else begin
            clr_addr_d = clr_addr_q + 1'b1;
          end
        end
        ST_DRAW: begin
          fb_addr_d = row_base_q + x_cur;
          fb_data_d = rect_q.color;
          fb_wren_d = ~empty & ~clip;
          if (last) begin
            rect_done_d[owner_q] = 1'b1;
            state_d              = ST_ARB;
          end else if (col_q == rect_q.w - 7'd1) begin
            col_d      = '0;
            row_d      = row_q + 7'd1;
            row_base_d = row_base_q + H_STEP;
          end else begin
            col_d = col_q + 7'd1;
          end
        end
        default: state_d = ST_ARB;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_ARB;
      ptr_q        <= '0;
      owner_q      <= '0;
      rect_q       <= '0;
      col_q        <= '0;
      row_q        <= '0;
      row_base_q   <= '0;
      clr_addr_q   <= '0;
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
      fb_wren_q    <= 1'b0;
      rect_done_q  <= '0;
      clear_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      rect_q       <= rect_d;
      col_q        <= col_d;
      row_q        <= row_d;
      row_base_q   <= row_base_d;
      clr_addr_q   <= clr_addr_d;
      fb_addr_q    <= fb_addr_d;
      fb_data_q    <= fb_data_d;
      fb_wren_q    <= fb_wren_d;
      rect_done_q  <= rect_done_d;
      clear_done_q <= clear_done_d;
      busy_q       <= (state_d != ST_ARB);
    end
  end

  assign bus.req_ready    = grant;
  assign bus.fb_wraddress = fb_addr_q;
  assign bus.fb_data      = fb_data_q;
  assign bus.fb_wren      = fb_wren_q;
  assign bus.rect_done    = rect_done_q;
  assign bus.clear_done   = clear_done_q;
  assign bus.busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_write_scheduler.sv
`default_nettype none
// ============================================================================
// tb_frame_write_scheduler : randomized scoreboard bench for frame_write_scheduler
// Revision: 1.0
// ============================================================================
module tb_frame_write_scheduler;
  import frame_write_pkg::*;

  localparam int         NR   = 4;
  localparam int         HR   = 40;
  localparam int         VR   = 24;
  localparam int         NPIX = HR * VR;
  localparam logic [7:0] CCOL = 8'h5A;

  logic Clk = 1'b0;
  logic reset_n = 1'b0;

  frame_write_scheduler_if #(.NUM_REQ(NR)) bus();

  frame_write_scheduler #(
    .NUM_REQ(NR), .H_RES(HR), .V_RES(VR), .CLEAR_COLOR(CCOL)
  ) dut (
    .Clk     (Clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  longint cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    longint          cyc;
    bit              wren;
    logic [18:0]     addr;
    logic [7:0]      data;
    logic [NR-1:0]   rdone;
    bit              cdone;
  } ev_t;

  ev_t exq[$];
  int  checks = 0;
  int  failures = 0;

  // Reference-model state: who is waiting, where the rr search starts, when idle.
  logic [NR-1:0] vld = '0;
  rect_t         desc [NR];
  int            m_ptr = 0;
  longint        free_cyc = 0;
  int            refresh_idx = -1;
  int            mode = 0;
  bit            log_en = 1'b0;
  longint        acc_cyc = -1;
  int            glog [$];
  longint        gcyc [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic rect_t mk(input int x, input int y, input int w, input int h, input int c);
    rect_t r;
    r.x = 10'(x); r.y = 10'(y); r.w = 7'(w); r.h = 7'(h); r.color = 8'(c);
    return r;
  endfunction

  function automatic rect_t rand_rect();
    rect_t r;
    r.x     = ($urandom_range(0, 15) == 0) ? 10'($urandom_range(1000, 1023)) : 10'($urandom_range(0, 45));
    r.y     = 10'($urandom_range(0, 28));
    r.w     = ($urandom_range(0, 9) == 0) ? 7'd0 : 7'($urandom_range(1, 12));
    r.h     = ($urandom_range(0, 9) == 0) ? 7'd0 : 7'($urandom_range(1, 6));
    r.color = 8'($urandom);
    return r;
  endfunction

  task automatic push_rect(input int idx, input rect_t r, input longint e_cyc);
    ev_t e;
    int  w, h, xc, yc, k;
    bit  inb, lst;
    w = int'(r.w);
    h = int'(r.h);
    if (w == 0 || h == 0) begin
      e.cyc = e_cyc + 1; e.wren = 1'b0; e.addr = '0; e.data = r.color;
      e.rdone = '0; e.rdone[idx] = 1'b1; e.cdone = 1'b0;
      exq.push_back(e);
    end else begin
      for (int row = 0; row < h; row++) begin
        for (int col = 0; col < w; col++) begin
          k   = row * w + col;
          lst = (k == w * h - 1);
          xc  = int'(r.x) + col;
          yc  = int'(r.y) + row;
          inb = (xc < HR) && (yc < VR);
          if (inb || lst) begin
            e.cyc = e_cyc + 1 + k; e.wren = inb;
            e.addr = inb ? 19'(yc * HR + xc) : 19'd0;
            e.data = r.color; e.rdone = '0; e.cdone = 1'b0;
            if (lst) e.rdone[idx] = 1'b1;
            exq.push_back(e);
          end
        end
      end
    end
  endtask

  // A clear cancels every expected output from its entry edge onwards.
  task automatic model_clear(input longint f_cyc);
    ev_t keep [$];
    ev_t e;
    foreach (exq[i]) if (exq[i].cyc < f_cyc) keep.push_back(exq[i]);
    exq = keep;
    for (int a = 0; a < NPIX; a++) begin
      e.cyc = f_cyc + 1 + a; e.wren = 1'b1; e.addr = 19'(a); e.data = CCOL;
      e.rdone = '0; e.cdone = (a == NPIX - 1);
      exq.push_back(e);
    end
    free_cyc = f_cyc + NPIX;
  endtask

  task automatic drive();
    for (int j = 0; j < NR; j++) begin
      bus.req_x[10*j +: 10]   = desc[j].x;
      bus.req_y[10*j +: 10]   = desc[j].y;
      bus.req_w[7*j +: 7]     = desc[j].w;
      bus.req_h[7*j +: 7]     = desc[j].h;
      bus.req_color[8*j +: 8] = desc[j].color;
    end
    bus.req_valid = vld;
  endtask

  task automatic step(input bit fs, input bit ce);
    logic [NR-1:0] exp_rdy;
    int            g, len;
    @(negedge Clk);
    if (refresh_idx >= 0) begin
      if (mode != 1) vld[refresh_idx] = 1'b0;
      refresh_idx = -1;
    end
    if (mode == 2)
      for (int j = 0; j < NR; j++)
        if (!vld[j] && $urandom_range(0, 7) == 0) begin
          desc[j] = rand_rect();
          vld[j]  = 1'b1;
        end
    drive();
    bus.frame_start = fs;
    bus.clear_en    = ce;
    #1;
    check("busy", 64'(bus.busy), 64'(cyc < free_cyc));
    exp_rdy = '0;
    g = -1;
    if (!(cyc < free_cyc) && !(fs && ce))
      for (int k = 0; k < NR; k++)
        if (g < 0 && vld[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    if (log_en)
      for (int j = 0; j < NR; j++)
        if (bus.req_ready[j] && bus.req_valid[j]) begin
          glog.push_back(j);
          gcyc.push_back(cyc + 1);
        end
    if (fs && ce) begin
      model_clear(cyc + 1);
    end else if (g >= 0) begin
      push_rect(g, desc[g], cyc + 1);
      len = (desc[g].w == 0 || desc[g].h == 0) ? 1 : int'(desc[g].w) * int'(desc[g].h);
      m_ptr       = (g + 1) % NR;
      free_cyc    = cyc + 1 + len;
      refresh_idx = g;
      acc_cyc     = cyc + 1;
    end
  endtask

  task automatic wait_idle();
    while (cyc < free_cyc + 1) step(1'b0, 1'b0);
  endtask

  task automatic wait_accept();
    acc_cyc = -1;
    for (int n = 0; n < 2000 && acc_cyc < 0; n++) step(1'b0, 1'b0);
    check("accept_timeout", 64'(acc_cyc >= 0), 64'd1);
  endtask

  always @(negedge Clk) begin
    if (reset_n) begin
      while (exq.size() > 0 && exq[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL missed_output: got none expected addr %0d rdone %b cdone %0d at cycle %0d",
                 exq[0].addr, exq[0].rdone, exq[0].cdone, exq[0].cyc);
        void'(exq.pop_front());
      end
      if (bus.fb_wren || (bus.rect_done != '0) || bus.clear_done) begin
        checks++;
        if (exq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output: got wren %0d addr %0d rdone %b cdone %0d expected nothing at cycle %0d",
                   bus.fb_wren, bus.fb_wraddress, bus.rect_done, bus.clear_done, cyc);
        end else begin
          ev_t e;
          e = exq.pop_front();
          if (e.cyc != cyc || e.wren != bus.fb_wren ||
              (e.wren && (e.addr !== bus.fb_wraddress || e.data !== bus.fb_data)) ||
              e.rdone !== bus.rect_done || e.cdone != bus.clear_done) begin
            failures++;
            $display("FAIL fb_event: got cyc %0d wren %0d addr %0d data %0h rdone %b cdone %0d expected cyc %0d wren %0d addr %0d data %0h rdone %b cdone %0d",
                     cyc, bus.fb_wren, bus.fb_wraddress, bus.fb_data, bus.rect_done, bus.clear_done,
                     e.cyc, e.wren, e.addr, e.data, e.rdone, e.cdone);
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order [5] = '{0, 1, 2, 3, 0};
    for (int j = 0; j < NR; j++) desc[j] = '0;
    drive();
    bus.frame_start = 1'b0;
    bus.clear_en    = 1'b0;

    repeat (3) @(negedge Clk);
    check("rst_wren",  64'(bus.fb_wren), 64'd0);
    check("rst_busy",  64'(bus.busy), 64'd0);
    check("rst_ready", 64'(bus.req_ready), 64'd0);
    check("rst_rdone", 64'(bus.rect_done), 64'd0);
    check("rst_cdone", 64'(bus.clear_done), 64'd0);
    check("rst_addr",  64'(bus.fb_wraddress), 64'd0);
    check("rst_data",  64'(bus.fb_data), 64'd0);
    reset_n = 1'b1;

    repeat (3) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    wait_idle();

    mode = 0;
    desc[1] = mk(10, 2, 3, 2, 8'hAB);
    vld = 4'b0010;
    wait_accept();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    wait_idle();

    desc[0] = mk(5, 3, 10, 10, 8'h77);
    vld = 4'b0001;
    wait_accept();
    repeat (4) step(1'b0, 1'b0);
    @(posedge Clk);
    #2;
    check("pre_reset_wren", 64'(bus.fb_wren), 64'd1);
    reset_n = 1'b0;
    #1;
    check("async_rst_wren", 64'(bus.fb_wren), 64'd0);
    check("async_rst_busy", 64'(bus.busy), 64'd0);
    check("async_rst_addr", 64'(bus.fb_wraddress), 64'd0);
    exq.delete();
    m_ptr = 0; free_cyc = 0; vld = '0; refresh_idx = -1;
    drive();
    @(negedge Clk);
    reset_n = 1'b1;

    mode = 1;
    for (int j = 0; j < NR; j++) desc[j] = mk(j * 8, 1, 2, 3, 8'h10 + j);
    vld = 4'hF;
    glog.delete();
    gcyc.delete();
    log_en = 1'b1;
    for (int n = 0; n < 80 && glog.size() < 5; n++) step(1'b0, 1'b0);
    log_en = 1'b0;
    mode = 0;
    vld = '0;
    refresh_idx = -1;
    wait_idle();
    check("grant_count", 64'(glog.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      if (i < glog.size()) begin
        check("grant_order", 64'(glog[i]), 64'(exp_order[i]));
        if (i > 0) check("grant_gap", 64'(gcyc[i] - gcyc[i-1]), 64'd7);
      end

    desc[2] = mk(HR - 2, VR - 1, 4, 2, 8'hC3);
    vld = 4'b0100;
    wait_accept();
    wait_idle();

    desc[3] = mk(3, 3, 0, 5, 8'h11);
    vld = 4'b1000;
    wait_accept();
    wait_idle();

    desc[2] = mk(5, 5, 10, 10, 8'hE7);
    vld = 4'b0100;
    wait_accept();
    repeat (3) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    repeat (100) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    wait_idle();

    mode = 2;
    for (int n = 0; n < 4000; n++) begin
      bit fs, ce;
      fs = ($urandom_range(0, 599) == 0);
      ce = fs ? ($urandom_range(0, 2) != 0) : 1'($urandom_range(0, 1));
      step(fs, ce);
    end
    mode = 0;
    vld = '0;
    refresh_idx = -1;
    wait_idle();
    repeat (3) step(1'b0, 1'b0);
    check("queue_drained", 64'(exq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
